// File: rtl/riscv_defs_pkg.sv
// Shared RV32I encoding constants, error codes and mnemonic decode for the text-to-instruction encoder.
// ABI_NAMES_EN widens the register token so ABI register names fit.
package riscv_defs_pkg;

    localparam int unsigned MNEM_LEN = 5;
    localparam int unsigned MNEM_W   = 8 * MNEM_LEN;
    localparam int unsigned TOK_W    = 32;
`ifdef ABI_NAMES_EN
    localparam int unsigned REG_TOK_MAX = 4;
`else
    localparam int unsigned REG_TOK_MAX = 3;
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_MNEM   = 3'd1;
    localparam logic [2:0] ERR_REG    = 3'd2;
    localparam logic [2:0] ERR_IMM    = 3'd3;
    localparam logic [2:0] ERR_SYNTAX = 3'd4;
    localparam logic [2:0] ERR_EMPTY  = 3'd5;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [2:0] {IDLE, MNEM, RD, RS1, OP3, EMIT, FLUSH} enc_state_t;

    typedef struct packed {
        logic       is_imm;
        logic       is_shift;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } mnem_info_t;

    typedef struct packed {
        logic       valid;
        mnem_info_t info;
    } mnem_dec_t;

    // Mnemonic buffer holds characters right-aligned, so it compares directly against string literals.
    function automatic mnem_dec_t mnem_decode(input logic [MNEM_W-1:0] m);
        mnem_dec_t d;
        d             = '0;
        d.valid       = 1'b1;
        d.info.funct7 = F7_BASE;
        case (m)
            40'("ADD"):   d.info.funct3 = F3_ADD;
            40'("SUB"):   begin d.info.funct3 = F3_ADD;  d.info.funct7 = F7_ALT; end
            40'("XOR"):   d.info.funct3 = F3_XOR;
            40'("OR"):    d.info.funct3 = F3_OR;
            40'("AND"):   d.info.funct3 = F3_AND;
            40'("SLL"):   d.info.funct3 = F3_SLL;
            40'("SRL"):   d.info.funct3 = F3_SR;
            40'("SRA"):   begin d.info.funct3 = F3_SR;   d.info.funct7 = F7_ALT; end
            40'("SLT"):   d.info.funct3 = F3_SLT;
            40'("SLTU"):  d.info.funct3 = F3_SLTU;
            40'("ADDI"):  begin d.info.funct3 = F3_ADD;  d.info.is_imm = 1'b1; end
            40'("XORI"):  begin d.info.funct3 = F3_XOR;  d.info.is_imm = 1'b1; end
            40'("ORI"):   begin d.info.funct3 = F3_OR;   d.info.is_imm = 1'b1; end
            40'("ANDI"):  begin d.info.funct3 = F3_AND;  d.info.is_imm = 1'b1; end
            40'("SLTI"):  begin d.info.funct3 = F3_SLT;  d.info.is_imm = 1'b1; end
            40'("SLTIU"): begin d.info.funct3 = F3_SLTU; d.info.is_imm = 1'b1; end
            40'("SLLI"):  begin d.info.funct3 = F3_SLL;  d.info.is_imm = 1'b1; d.info.is_shift = 1'b1; end
            40'("SRLI"):  begin d.info.funct3 = F3_SR;   d.info.is_imm = 1'b1; d.info.is_shift = 1'b1; end
            40'("SRAI"):  begin
                d.info.funct3   = F3_SR;
                d.info.funct7   = F7_ALT;
                d.info.is_imm   = 1'b1;
                d.info.is_shift = 1'b1;
            end
            default:      d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/asm_reg_parse.sv
// Converts a right-aligned register token (X0..X31, plus ABI names when ABI_NAMES_EN) to a register index.
module asm_reg_parse
    import riscv_defs_pkg::*;
(
    input  logic [TOK_W-1:0] i_tok,
    output logic [4:0]       o_idx_c,
    output logic             o_valid_c
);

    logic [7:0] w_b0, w_b1, w_b2, w_b3;
    logic [7:0] w_d0, w_d1, w_two_digit;
    logic       w_dig0, w_len2, w_len3;

    assign w_b0        = i_tok[7:0];
    assign w_b1        = i_tok[15:8];
    assign w_b2        = i_tok[23:16];
    assign w_b3        = i_tok[31:24];
    assign w_d0        = w_b0 - CH_ZERO;
    assign w_d1        = w_b1 - CH_ZERO;
    assign w_two_digit = 8'(w_d1 * 8'd10) + w_d0;
    assign w_dig0      = (w_b0 >= "0") && (w_b0 <= "9");
    assign w_len2      = (w_b3 == 8'h00) && (w_b2 == 8'h00) && (w_b1 != 8'h00);
    assign w_len3      = (w_b3 == 8'h00) && (w_b2 != 8'h00);

    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        // Two-digit form rejects a leading zero by requiring the tens digit to be 1..3.
        if (w_len2 && w_b1 == "X" && w_dig0) begin
            o_idx_c   = 5'(w_d0);
            o_valid_c = 1'b1;
        end else if (w_len3 && w_b2 == "X" && w_b1 >= "1" && w_b1 <= "3" && w_dig0
                     && w_two_digit <= 8'd31) begin
            o_idx_c   = 5'(w_two_digit);
            o_valid_c = 1'b1;
        end
`ifdef ABI_NAMES_EN
        if (!o_valid_c) begin
            o_valid_c = 1'b1;
            if (i_tok == 32'("ZERO"))                               o_idx_c = 5'd0;
            else if (i_tok == 32'("RA"))                            o_idx_c = 5'd1;
            else if (i_tok == 32'("SP"))                            o_idx_c = 5'd2;
            else if (i_tok == 32'("GP"))                            o_idx_c = 5'd3;
            else if (i_tok == 32'("TP"))                            o_idx_c = 5'd4;
            else if (i_tok == 32'("S10"))                           o_idx_c = 5'd26;
            else if (i_tok == 32'("S11"))                           o_idx_c = 5'd27;
            else if (w_len2 && w_dig0 && w_b1 == "T" && w_d0 <= 8'd2) o_idx_c = 5'(w_d0 + 8'd5);
            else if (w_len2 && w_dig0 && w_b1 == "T" && w_d0 <= 8'd6) o_idx_c = 5'(w_d0 + 8'd25);
            else if (w_len2 && w_dig0 && w_b1 == "S" && w_d0 <= 8'd1) o_idx_c = 5'(w_d0 + 8'd8);
            else if (w_len2 && w_dig0 && w_b1 == "S")               o_idx_c = 5'(w_d0 + 8'd16);
            else if (w_len2 && w_dig0 && w_b1 == "A" && w_d0 <= 8'd7) o_idx_c = 5'(w_d0 + 8'd10);
            else                                                    o_valid_c = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams uppercase assembly text one character at a time and emits the RV32I R/I-type ALU encoding.
// Define ABI_NAMES_EN to accept ABI register names in addition to X0..X31.
module instr_encoder
    import riscv_defs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        err,
    output logic [2:0]  err_code
);

    enc_state_t        r_state, w_next_state;
    logic [MNEM_W-1:0] r_mnem;
    logic [2:0]        r_mnem_len;
    logic [TOK_W-1:0]  r_tok;
    logic [2:0]        r_tok_len;
    logic [12:0]       r_imm_mag;
    logic              r_imm_neg, r_imm_any;
    logic [4:0]        r_rd, r_rs1;
    mnem_info_t        r_info;
    logic [2:0]        r_pend_code;
    logic              r_char_ready, r_instr_valid, r_err;
    logic [31:0]       r_instr;
    logic [2:0]        r_err_code;

    logic              w_fire, w_is_term, w_is_digit, w_is_letter, w_is_space, w_is_comma, w_is_minus;
    mnem_dec_t         w_dec;
    logic [4:0]        w_reg_idx;
    logic              w_reg_valid, w_imm_in_range;
    logic [16:0]       w_imm_next;
    logic [11:0]       w_imm12;
    logic [31:0]       w_instr_enc;
    logic              w_err_hit, w_err_pulse, w_line_start, w_mnem_push, w_tok_push, w_tok_clr;
    logic              w_latch_info, w_latch_rd, w_latch_rs1, w_imm_digit, w_imm_neg_set;
    logic              w_emit, w_consume;
    logic [2:0]        w_err_code, w_pulse_code;

    assign char_ready  = r_char_ready;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign err         = r_err;
    assign err_code    = r_err_code;

    assign w_fire      = char_valid && r_char_ready;
    assign w_is_term   = (char_in == CH_LF) || (char_in == CH_SEMI);
    assign w_is_digit  = (char_in >= "0") && (char_in <= "9");
    assign w_is_letter = (char_in >= "A") && (char_in <= "Z");
    assign w_is_space  = (char_in == CH_SPACE);
    assign w_is_comma  = (char_in == CH_COMMA);
    assign w_is_minus  = (char_in == CH_MINUS);
    assign w_dec       = mnem_decode(r_mnem);
    assign w_imm_next  = 17'(r_imm_mag) * 17'd10 + 17'(char_in - CH_ZERO);

    asm_reg_parse u_reg_parse (
        .i_tok     (r_tok),
        .o_idx_c   (w_reg_idx),
        .o_valid_c (w_reg_valid)
    );

    // Immediate range and 12-bit field; shifts carry funct7 in the upper immediate bits.
    always_comb begin
        if (r_info.is_shift) begin
            w_imm_in_range = (r_imm_mag <= 13'd31) && (!r_imm_neg || r_imm_mag == '0);
            w_imm12        = {r_info.funct7, r_imm_mag[4:0]};
        end else begin
            w_imm_in_range = r_imm_neg ? (r_imm_mag <= 13'd2048) : (r_imm_mag <= 13'd2047);
            w_imm12        = r_imm_neg ? 12'(13'd0 - r_imm_mag) : 12'(r_imm_mag);
        end
        if (r_info.is_imm) w_instr_enc = {w_imm12, r_rs1, r_info.funct3, r_rd, OPC_OP_IMM};
        else               w_instr_enc = {r_info.funct7, w_reg_idx, r_rs1, r_info.funct3, r_rd, OPC_OP};
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_err_hit     = 1'b0;
        w_err_code    = ERR_NONE;
        w_err_pulse   = 1'b0;
        w_pulse_code  = r_pend_code;
        w_line_start  = 1'b0;
        w_mnem_push   = 1'b0;
        w_tok_push    = 1'b0;
        w_tok_clr     = 1'b0;
        w_latch_info  = 1'b0;
        w_latch_rd    = 1'b0;
        w_latch_rs1   = 1'b0;
        w_imm_digit   = 1'b0;
        w_imm_neg_set = 1'b0;
        w_emit        = 1'b0;
        w_consume     = 1'b0;
        case (r_state)
            IDLE: if (w_fire && !w_is_term) begin
                if (w_is_letter) begin
                    w_line_start = 1'b1;
                    w_next_state = MNEM;
                end else if (w_is_space) begin w_err_hit = 1'b1; w_err_code = ERR_EMPTY;  end
                else                     begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
            end
            MNEM: if (w_fire) begin
                if (w_is_letter) begin
                    if (r_mnem_len == 3'(MNEM_LEN)) begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
                    else w_mnem_push = 1'b1;
                end else if (w_is_space) begin
                    if (!w_dec.valid) begin w_err_hit = 1'b1; w_err_code = ERR_MNEM; end
                    else begin
                        w_latch_info = 1'b1;
                        w_tok_clr    = 1'b1;
                        w_next_state = RD;
                    end
                end else begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
            end
            RD, RS1, OP3: if (w_fire) begin
                if (r_state == OP3 && r_info.is_imm) begin
                    if (w_is_term) begin
                        if (!r_imm_any)           begin w_err_hit = 1'b1; w_err_code = ERR_EMPTY; end
                        else if (!w_imm_in_range) begin w_err_hit = 1'b1; w_err_code = ERR_IMM;   end
                        else begin
                            w_emit       = 1'b1;
                            w_next_state = EMIT;
                        end
                    end else if (w_is_digit) w_imm_digit = 1'b1;
                    else if (w_is_minus && !r_imm_any && !r_imm_neg) w_imm_neg_set = 1'b1;
                    else if (!(w_is_space && !r_imm_any && !r_imm_neg)) begin
                        w_err_hit  = 1'b1;
                        w_err_code = ERR_SYNTAX;
                    end
                end else if ((r_state == OP3) ? w_is_term : w_is_comma) begin
                    if (r_tok_len == '0)   begin w_err_hit = 1'b1; w_err_code = ERR_EMPTY; end
                    else if (!w_reg_valid) begin w_err_hit = 1'b1; w_err_code = ERR_REG;   end
                    else begin
                        w_tok_clr = 1'b1;
                        case (r_state)
                            RD:      begin w_latch_rd  = 1'b1; w_next_state = RS1;  end
                            RS1:     begin w_latch_rs1 = 1'b1; w_next_state = OP3;  end
                            default: begin w_emit      = 1'b1; w_next_state = EMIT; end
                        endcase
                    end
                end else if (w_is_term || w_is_comma) begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
                else if (w_is_space) begin
                    // Leading spaces in a field are skipped; a space inside a token is a syntax error.
                    if (r_tok_len != '0) begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
                end else if (r_tok_len == 3'(REG_TOK_MAX)) begin w_err_hit = 1'b1; w_err_code = ERR_SYNTAX; end
                else w_tok_push = 1'b1;
            end
            EMIT: if (instr_ready) begin
                w_consume    = 1'b1;
                w_next_state = IDLE;
            end
            FLUSH: if (w_fire && w_is_term) begin
                w_err_pulse  = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        // An error found on the terminator itself has nothing left to flush.
        if (w_err_hit) begin
            if (w_is_term) begin
                w_err_pulse  = 1'b1;
                w_pulse_code = w_err_code;
                w_next_state = IDLE;
            end else begin
                w_next_state = FLUSH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mnem        <= '0;
            r_mnem_len    <= '0;
            r_tok         <= '0;
            r_tok_len     <= '0;
            r_imm_mag     <= '0;
            r_imm_neg     <= 1'b0;
            r_imm_any     <= 1'b0;
            r_rd          <= '0;
            r_rs1         <= '0;
            r_info        <= '0;
            r_pend_code   <= ERR_NONE;
            r_char_ready  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_char_ready <= (w_next_state != EMIT);
            r_err        <= w_err_pulse;
            if (w_err_pulse) r_err_code  <= w_pulse_code;
            if (w_err_hit)   r_pend_code <= w_err_code;
            if (w_line_start) begin
                r_mnem     <= MNEM_W'(char_in);
                r_mnem_len <= 3'd1;
                r_tok      <= '0;
                r_tok_len  <= '0;
                r_imm_mag  <= '0;
                r_imm_neg  <= 1'b0;
                r_imm_any  <= 1'b0;
            end else if (w_mnem_push) begin
                r_mnem     <= {r_mnem[MNEM_W-9:0], char_in};
                r_mnem_len <= r_mnem_len + 3'd1;
            end
            if (w_tok_clr) begin
                r_tok     <= '0;
                r_tok_len <= '0;
            end else if (w_tok_push) begin
                r_tok     <= {r_tok[TOK_W-9:0], char_in};
                r_tok_len <= r_tok_len + 3'd1;
            end
            if (w_latch_info)  r_info    <= w_dec.info;
            if (w_latch_rd)    r_rd      <= w_reg_idx;
            if (w_latch_rs1)   r_rs1     <= w_reg_idx;
            if (w_imm_neg_set) r_imm_neg <= 1'b1;
            // Magnitude saturates well above 2048 so long digit strings still read as out of range.
            if (w_imm_digit) begin
                r_imm_mag <= (w_imm_next > 17'd4095) ? 13'd4095 : 13'(w_imm_next);
                r_imm_any <= 1'b1;
            end
            if (w_emit) begin
                r_instr       <= w_instr_enc;
                r_instr_valid <= 1'b1;
            end else if (w_consume) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, error codes, stalls and resets.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        bit done;
        bit rdy;
        done       = 1'b0;
        char_in    = c;
        char_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = char_ready;
            step();
            done = rdy;
        end
        char_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL char_accept: char %02h not taken within 20 cycles", c);
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check(tag, instr, exp);
        check({tag, "_noerr"}, 32'(err), 32'd0);
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("consume_valid_low", 32'(instr_valid), 32'd0);
        check("consume_ready_high", 32'(char_ready), 32'd1);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_novalid"}, 32'(instr_valid), 32'd0);
        step();
        check({tag, "_err_oneshot"}, 32'(err), 32'd0);
        check({tag, "_code_held"}, 32'(err_code), 32'(code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd1);

        send_line("ADD X1,X2,X3\n");
        expect_instr("add", 32'h003100B3);
        check("emit_ready_low", 32'(char_ready), 32'd0);
        consume();

        send_line("ADDI X5,X0,-1;");
        expect_instr("addi_neg", 32'hFFF00293);
        consume();

        send_line("SRAI X1,X2,3\n");
        expect_instr("srai", 32'h40315093);
        consume();

        send_line("SUB X1,X2,X3\n");
        expect_instr("sub", 32'h403100B3);
        consume();

        send_line("ADDI X1,X2,2048\n");
        expect_err("imm_2048", 3'd3);
        send_line("ADDI X1,X2,-2048\n");
        expect_instr("imm_m2048", 32'h80010093);
        consume();
        send_line("ADDI X1,X2,2047\n");
        expect_instr("imm_2047", 32'h7FF10093);
        consume();

        send_line("OR X1, X2, X3\n");
        expect_instr("or_spaces", 32'h003160B3);
        consume();
        send_line("SLTU X3,X4,X5\n");
        expect_instr("sltu", 32'h005231B3);
        consume();
        send_line("SRA X2,X3,X4\n");
        expect_instr("sra", 32'h4041D133);
        consume();
        send_line("ANDI X7,X8,255\n");
        expect_instr("andi", 32'h0FF47393);
        consume();
        send_line("SLLI X1,X2,31\n");
        expect_instr("slli_31", 32'h01F11093);
        consume();

        // Consumer stalls for five cycles in EMIT.
        send_line("ADD X1,X2,X3\n");
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", 32'(char_ready), 32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, 32'h003100B3);
            step();
        end
        consume();
        send_line("XOR X31,X30,X29\n");
        expect_instr("xor_after_stall", 32'h01DF4FB3);
        consume();

        send_line("FOO X1,X2,X3\n");
        expect_err("unk_mnem", 3'd1);
        send_line("ADD X1,X32,X3\n");
        expect_err("reg_32", 3'd2);
        send_line("ADD X1,X01,X3\n");
        expect_err("reg_lead0", 3'd2);
        send_line("SLLI X1,X2,32\n");
        expect_err("shamt_32", 3'd3);
        send_line("ADDIXY X1,X2,3\n");
        expect_err("mnem_long", 3'd4);
        send_line("ADD X1,,X3\n");
        expect_err("empty_rs1", 3'd5);

        send_line("\n");
        check("empty_line_err", 32'(err), 32'd0);
        check("empty_line_valid", 32'(instr_valid), 32'd0);
        check("empty_line_code", 32'(err_code), 32'd5);

        send_line("ADD A0,SP,T0\n");
`ifdef ABI_NAMES_EN
        expect_instr("abi_add", 32'h00510533);
        consume();
`else
        expect_err("abi_add", 3'd2);
`endif

        // Reset partway through a line drops it silently.
        send_line("ADD X1,");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midline_rst_err", 32'(err), 32'd0);
        check("midline_rst_code", 32'(err_code), 32'd0);
        check("midline_rst_ready", 32'(char_ready), 32'd1);
        send_line("AND X1,X2,X3\n");
        expect_instr("and_after_rst", 32'h003170B3);

        // Reset while an instruction waits in EMIT discards it.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("emit_rst_valid", 32'(instr_valid), 32'd0);
        check("emit_rst_instr", instr, 32'h0);
        check("emit_rst_ready", 32'(char_ready), 32'd1);
        step();
        check("emit_rst_noerr", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
